// File: rtl/wb_apb_bridge.sv
// Wishbone classic slave to APB3 master bridge: one APB transfer per Wishbone access,
// with wait states from pready, pslverr mapped to wb_err, and a stuck-pready timeout.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   wb_cyc/stb/we/adr      Wishbone request; wb_wdata write data
//   wb_rdata/ack/err       Wishbone response (ack/err are single-cycle pulses)
//   paddr/psel/penable     APB address phase
//   pwrite/pwdata          APB direction and write data
//   prdata/pready/pslverr  APB completion from the peripheral
module wb_apb_bridge #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned APB_ADDR_W = 16,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [31:0]           wb_adr,
    input  logic [DATA_W-1:0]     wb_wdata,
    output logic [DATA_W-1:0]     wb_rdata,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    logic                  abort_now;
    logic [APB_ADDR_W-1:0] paddr_d;
    logic                  psel_d, penable_d, pwrite_d;
    logic [DATA_W-1:0]     pwdata_d, rdata_d;
    logic                  ack_d, err_d;

    // Upper address bits are decoded upstream.
    logic adr_hi_unused;
    assign adr_hi_unused = ^wb_adr[31:APB_ADDR_W];

    // State and all outputs registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            paddr    <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            wb_rdata <= '0;
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            paddr    <= paddr_d;
            psel     <= psel_d;
            penable  <= penable_d;
            pwrite   <= pwrite_d;
            pwdata   <= pwdata_d;
            wb_rdata <= rdata_d;
            wb_ack   <= ack_d;
            wb_err   <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        abort_now = abort_q | ~wb_cyc;
        paddr_d   = paddr;
        psel_d    = psel;
        penable_d = penable;
        pwrite_d  = pwrite;
        pwdata_d  = pwdata;
        rdata_d   = wb_rdata;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    paddr_d   = wb_adr[APB_ADDR_W-1:0];
                    pwrite_d  = wb_we;
                    pwdata_d  = wb_we ? wb_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    abort_d   = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                abort_d   = abort_now;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A master that dropped cyc still lets the APB transfer finish, silently.
                abort_d = abort_now;
                if (pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = RESP;
                    if (!abort_now) begin
                        ack_d = ~pslverr;
                        err_d = pslverr;
                        if (!pwrite) begin
                            rdata_d = prdata;
                        end
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = RESP;
                    if (!abort_now) begin
                        err_d = 1'b1;
                        if (!pwrite) begin
                            rdata_d = DATA_W'(32'hDEAD_BEEF);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // ack/err are already driven for this cycle; no new request is taken.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_apb_bridge.sv
module tb_wb_apb_bridge;

    localparam int unsigned TMO = 16;

    logic        clk, rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_wdata, wb_rdata;
    logic        wb_ack, wb_err;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rdata;

    wb_apb_bridge #(.DATA_W(32), .APB_ADDR_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_ack(wb_ack), .wb_err(wb_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] prd;
        int          wt;        // ACCESS cycles with pready low before it rises
        logic        slverr;
        int          abort_at;  // edge index from which cyc is low; 0 = never
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;   // cycles from stb sample to the response pulse
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: response type, data and latency from the bridge's rules.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t r;
        logic timed_out;
        r = v;
        timed_out = (v.wt >= int'(TMO));
        r.exp_lat = timed_out ? 2 + int'(TMO) : 3 + v.wt;
        if (v.abort_at != 0) begin
            r.exp_ack = 1'b0; r.exp_err = 1'b0; r.exp_rdata = prev;
        end else if (timed_out) begin
            r.exp_ack = 1'b0; r.exp_err = 1'b1;
            r.exp_rdata = v.we ? prev : 32'hDEAD_BEEF;
        end else begin
            r.exp_ack = ~v.slverr; r.exp_err = v.slverr;
            r.exp_rdata = v.we ? prev : v.prd;
        end
        return r;
    endfunction

    // Drives one Wishbone access from a negedge, checking APB and WB signals every cycle.
    task automatic run_vec(input vec_t v);
        int done_e;
        done_e   = v.exp_lat - 1;
        wb_cyc   = 1'b1; wb_stb = 1'b1; wb_we = v.we;
        wb_adr   = v.adr; wb_wdata = v.wdata;
        prdata   = v.prd; pslverr = v.slverr; pready = 1'b0;
        for (int i = 0; i <= done_e + 1; i++) begin
            if ((v.abort_at != 0 && i >= v.abort_at) || i == done_e + 1) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
            pready = (i >= v.wt + 2);
            @(posedge clk);
            @(negedge clk);
            chk("psel", 32'(psel), 32'(i < done_e));
            chk("penable", 32'(penable), 32'(i >= 1 && i < done_e));
            chk("wb_ack", 32'(wb_ack), 32'(i == done_e && v.exp_ack));
            chk("wb_err", 32'(wb_err), 32'(i == done_e && v.exp_err));
            if (i < done_e) begin
                chk("paddr", 32'(paddr), {16'h0, v.adr[15:0]});
                chk("pwrite", 32'(pwrite), 32'(v.we));
                chk("pwdata", pwdata, v.we ? v.wdata : 32'h0);
            end
        end
        chk("wb_rdata", wb_rdata, v.exp_rdata);
        pready = 1'b0; pslverr = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                                input logic [31:0] prd, input int wt, input logic se,
                                input int ab, input logic ea, input logic ee,
                                input logic [31:0] er, input int lat);
        vec_t v;
        v.we = we; v.adr = adr; v.wdata = wd; v.prd = prd; v.wt = wt; v.slverr = se;
        v.abort_at = ab; v.exp_ack = ea; v.exp_err = ee; v.exp_rdata = er; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        int   done_e;

        tbl[0]  = mk(1, 32'h0000_1004, 32'hA5A5_0001, 32'h0,         0,   0, 0, 1, 0, 32'h0,         3);
        tbl[1]  = mk(0, 32'h0000_0008, 32'h0,         32'h1234_5678, 5,   0, 0, 1, 0, 32'h1234_5678, 8);
        tbl[2]  = mk(0, 32'h0000_0010, 32'h0,         32'hCAFE_0003, 0,   1, 0, 0, 1, 32'hCAFE_0003, 3);
        tbl[3]  = mk(0, 32'h0000_0020, 32'h0,         32'h5555_5555, 100, 0, 0, 0, 1, 32'hDEAD_BEEF, 18);
        tbl[4]  = mk(1, 32'h0000_0024, 32'h0000_0042, 32'h0,         0,   0, 0, 1, 0, 32'hDEAD_BEEF, 3);
        tbl[5]  = mk(0, 32'hFFFF_2030, 32'h0,         32'h0BAD_F00D, 15,  0, 0, 1, 0, 32'h0BAD_F00D, 18);
        tbl[6]  = mk(0, 32'h0000_0040, 32'h0,         32'h7777_7777, 16,  0, 0, 0, 1, 32'hDEAD_BEEF, 18);
        tbl[7]  = mk(0, 32'h0000_0044, 32'h0,         32'h1111_1111, 2,   0, 2, 0, 0, 32'hDEAD_BEEF, 5);
        tbl[8]  = mk(1, 32'h0000_0048, 32'h5555_AAAA, 32'h0,         1,   1, 1, 0, 0, 32'hDEAD_BEEF, 4);
        tbl[9]  = mk(1, 32'h0000_004C, 32'h0000_0001, 32'h0,         0,   1, 0, 0, 1, 32'hDEAD_BEEF, 3);
        tbl[10] = mk(0, 32'h0000_0050, 32'h0,         32'h89AB_CDEF, 3,   0, 0, 1, 0, 32'h89AB_CDEF, 6);

        rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_wdata = '0;
        prdata = '0; pready = 0; pslverr = 0;
        @(negedge clk); @(negedge clk);
        chk("rst psel", 32'(psel), 32'h0);
        chk("rst penable", 32'(penable), 32'h0);
        chk("rst wb_ack", 32'(wb_ack), 32'h0);
        chk("rst wb_err", 32'(wb_err), 32'h0);
        chk("rst wb_rdata", wb_rdata, 32'h0);
        chk("rst paddr", 32'(paddr), 32'h0);
        chk("rst pwdata", pwdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 11; k++) run_vec(tbl[k]);
        model_rdata = 32'h89AB_CDEF;

        for (int k = 0; k < 40; k++) begin
            v.we = 1'($urandom % 2);
            v.adr = $urandom; v.wdata = $urandom; v.prd = $urandom;
            v.wt = (($urandom % 8) < 5) ? int'($urandom % 4) : 13 + int'($urandom % 6);
            v.slverr = (($urandom % 4) == 0);
            done_e = ((v.wt < int'(TMO)) ? v.wt : int'(TMO) - 1) + 2;
            v.abort_at = (($urandom % 8) == 0) ? 1 + int'($urandom % 32'(done_e)) : 0;
            v = model(v, model_rdata);
            run_vec(v);
            model_rdata = v.exp_rdata;
        end

        // Reset in the middle of an ACCESS phase.
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h0000_0060; pready = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
        end
        chk("pre-rst psel", 32'(psel), 32'h1);
        chk("pre-rst penable", 32'(penable), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async psel", 32'(psel), 32'h0);
        chk("async penable", 32'(penable), 32'h0);
        chk("async wb_ack", 32'(wb_ack), 32'h0);
        chk("async wb_err", 32'(wb_err), 32'h0);
        @(negedge clk);
        wb_cyc = 0; wb_stb = 0; rst = 1'b0;
        @(negedge clk);
        chk("post-rst wb_rdata", wb_rdata, 32'h0);
        run_vec(mk(1, 32'h0000_1008, 32'h0F0F_F0F0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
